// File: rtl/cpu_pkg.sv
// Shared CPU definitions.
// Holds the PC-sequencer state encoding, default fetch-address parameters and
// the HALT opcode the decoder matches to raise halt_req.
package cpu_pkg;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        FLUSH = 2'd1,
        HALT  = 2'd2
    } pc_seq_state_t;

    localparam int unsigned ADDR_W_DEFAULT = 16;
    localparam logic [ADDR_W_DEFAULT-1:0] RESET_PC_DEFAULT = '0;

    // Major opcode the decoder compares against to form halt_req.
    localparam logic [6:0] OPCODE_HALT = 7'b111_1111;

endpackage

// File: rtl/flush_counter.sv
// Down-counter that times the post-redirect flush window.
// Ports:
//   clk, rst  - clock, asynchronous active-high reset (count cleared to 0)
//   load      - load load_val (has priority over dec)
//   load_val  - value loaded when load is high
//   dec       - decrement by one (saturates at 0)
//   last      - count is exactly 1, i.e. the next decrement ends the window
module flush_counter #(
    parameter int unsigned WIDTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             dec,
    output logic             last
);

    logic [WIDTH-1:0] count_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else if (load) begin
            count_q <= load_val;
        end else if (dec && (count_q != '0)) begin
            count_q <= count_q - WIDTH'(1);
        end
    end

    assign last = (count_q == WIDTH'(1));

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer for the fetch stage.
// Holds the PC, picks the next fetch address (sequential, branch target or
// hold), squashes wrong-path instructions after a taken redirect and owns the
// halt state.
// Ports:
//   clk, rst     - clock, asynchronous active-high reset
//   stall        - front-end hazard stall, holds the PC
//   br_valid     - EX holds a branch/jump
//   br_cond_met  - branch condition result
//   is_jump      - unconditional jump (taken regardless of br_cond_met)
//   br_target    - redirect address from EX
//   halt_req     - EX instruction is HALT
//   pc           - current fetch address (registered)
//   pc_plus1     - pc + 1, wrapping
//   flush        - squash IF/ID and ID/EX (combinational)
//   redirect     - taken redirect accepted this cycle (combinational)
//   halted       - core halted (registered)
module pc_sequencer
    import cpu_pkg::*;
#(
    parameter int unsigned          ADDR_W       = ADDR_W_DEFAULT,
    parameter logic [ADDR_W-1:0]    RESET_PC     = ADDR_W'(RESET_PC_DEFAULT),
    parameter int unsigned          FLUSH_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              br_valid,
    input  logic              br_cond_met,
    input  logic              is_jump,
    input  logic [ADDR_W-1:0] br_target,
    input  logic              halt_req,
    output logic [ADDR_W-1:0] pc,
    output logic [ADDR_W-1:0] pc_plus1,
    output logic              flush,
    output logic              redirect,
    output logic              halted
);

    localparam int unsigned CNT_W = $clog2(FLUSH_CYCLES + 1);

    pc_seq_state_t     state_q, state_d;
    logic [ADDR_W-1:0] pc_d;
    logic              taken;
    logic              flush_raw;
    logic              redirect_raw;
    logic              cnt_load;
    logic              cnt_dec;
    logic              cnt_last;

    assign taken    = br_valid & (is_jump | br_cond_met);
    assign pc_plus1 = pc + ADDR_W'(1);

    always_comb begin
        state_d      = state_q;
        pc_d         = pc;
        flush_raw    = 1'b0;
        redirect_raw = 1'b0;
        cnt_load     = 1'b0;
        cnt_dec      = 1'b0;
        unique case (state_q)
            RUN: begin
                // A taken redirect wins over stall: the wrong-path fetch must go.
                if (taken) begin
                    redirect_raw = 1'b1;
                    flush_raw    = 1'b1;
                    pc_d         = br_target;
                    cnt_load     = 1'b1;
                    // The redirect cycle itself is the first flush cycle.
                    if (FLUSH_CYCLES > 1) begin
                        state_d = FLUSH;
                    end
                end else if (halt_req) begin
                    state_d = HALT;
                end else if (!stall) begin
                    pc_d = pc_plus1;
                end
            end
            FLUSH: begin
                // Branch/halt requests here come from squashed instructions.
                flush_raw = 1'b1;
                if (!stall) begin
                    pc_d    = pc_plus1;
                    cnt_dec = 1'b1;
                    if (cnt_last) begin
                        state_d = RUN;
                    end
                end
            end
            HALT: begin
                state_d = HALT;
            end
            default: begin
                state_d = RUN;
            end
        endcase
    end

    // Pipeline clears must stay quiet while reset is held.
    assign flush    = flush_raw & ~rst;
    assign redirect = redirect_raw & ~rst;
    assign halted   = (state_q == HALT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= RUN;
            pc      <= RESET_PC;
        end else begin
            state_q <= state_d;
            pc      <= pc_d;
        end
    end

    flush_counter #(
        .WIDTH (CNT_W)
    ) u_flush_counter (
        .clk      (clk),
        .rst      (rst),
        .load     (cnt_load),
        .load_val (CNT_W'(FLUSH_CYCLES - 1)),
        .dec      (cnt_dec),
        .last     (cnt_last)
    );

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Program-counter sequencer for the CPU's fetch stage. It sits directly downstream of the branch-condition logic and consumes its taken/not-taken result (`br_cond_met`) together with the EX-stage branch target. It holds the PC, selects the next fetch address, and drives the IF/ID squash for wrong-path instructions. It also owns the processor halt state.

## Interface
- `ADDR_W`, 16: PC width in bits; the PC is word-addressed.
- `RESET_PC`, 0: PC value loaded on reset.
- `FLUSH_CYCLES`, 2: number of cycles `flush` is asserted per redirect; legal range is 1..7.

- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `stall`  in  1  front-end hazard stall; holds the PC.
- `br_valid`  in  1  EX stage holds a branch or jump instruction.
- `br_cond_met`  in  1  branch condition result from the branch-condition logic.
- `is_jump`  in  1  EX instruction is an unconditional jump; taken regardless of `br_cond_met`.
- `br_target`  in  ADDR_W  redirect address from EX.
- `halt_req`  in  1  EX instruction is HALT.
- `pc`  out  ADDR_W  current fetch address, registered.
- `pc_plus1`  out  ADDR_W  `pc`+1 modulo 2^ADDR_W, combinational.
- `flush`  out  1  squash the IF/ID and ID/EX contents.
- `redirect`  out  1  a taken redirect is accepted this cycle.
- `halted`  out  1  core halted, registered.

## Operation
- `taken` = `br_valid` & (`is_jump` | `br_cond_met`).
- FSM states are RUN, FLUSH and HALT. Reset enters RUN with `pc`=`RESET_PC`, flush counter 0, `halted`=0.
- In RUN:
  - If `taken`: `redirect`=1 and `flush`=1 this cycle. Next edge loads `pc`<=`br_target`.
  - After a `taken` redirect, the next state is FLUSH with counter=`FLUSH_CYCLES`-1. If `FLUSH_CYCLES`=1, the next state is RUN.
  - `taken` has priority over `stall`: the redirect happens even when `stall`=1.
  - Else if `halt_req` (and not `taken`): next state is HALT and `pc` holds.
  - Else if `stall`: `pc` holds.
  - Else: `pc`<=`pc`+1.
- In FLUSH:
  - `flush`=1.
  - `br_valid`, `taken` and `halt_req` are ignored, because they come from squashed wrong-path instructions. `redirect`=0.
  - If `stall`=0: `pc`<=`pc`+1 and the counter decrements. When the counter is 1 at that edge, the next state is RUN.
  - If `stall`=1: `pc` and the counter both hold.
- In HALT:
  - `halted`=1, `pc` frozen, all inputs ignored, `flush`=0, `redirect`=0.
  - Only `rst` exits HALT.
- PC arithmetic is unsigned modulo 2^ADDR_W: `pc`=2^ADDR_W-1 increments to 0. `br_target` is used as given, with no alignment check.

## Timing
- Redirect latency: `taken` sampled in cycle N; `pc`=`br_target` from cycle N+1.
- `flush` is high for exactly `FLUSH_CYCLES` non-stalled cycles, starting combinationally in cycle N. Stalled cycles extend the flush window.
- Halt latency: `halt_req` in cycle N; `halted`=1 and `pc` frozen from cycle N+1. The PC after halt equals the PC in cycle N.
- Outputs during reset: `pc`=`RESET_PC`, `halted`=0, `flush`=0, `redirect`=0.
- Reset asserted mid-FLUSH or mid-HALT immediately clears state to RUN and the counter to 0 asynchronously. The first fetch after deassertion is `RESET_PC`.
- `pc_plus1` is combinational from `pc`. `flush` and `redirect` are combinational from state plus `taken`; they must settle within the cycle for the pipeline-register clear.

## Structure
- Shared package `cpu_pkg` holds:
  - the `pc_seq_state_t` enum (RUN, FLUSH, HALT);
  - `ADDR_W` and `RESET_PC` defaults;
  - the HALT opcode constant used by the decoder to form `halt_req`.
- One sub-module, `flush_counter`:
  - load/decrement-with-enable down-counter of width $clog2(`FLUSH_CYCLES`+1);
  - async reset to 0;
  - provides `last`, asserted when the count is 1.
- Everything else (FSM, PC register, next-PC mux) lives in `pc_sequencer`.

## Test plan
- Reset then 4 unstalled cycles with `RESET_PC`=0x0010 → `pc` sequence 0x10, 0x11, 0x12, 0x13; `flush`=0 throughout.
- `br_valid`=1, `br_cond_met`=1, `br_target`=0x0200 at `pc`=0x0013 → `redirect`=`flush`=1 that cycle; `pc`=0x0200 next cycle; `flush`=1 for one more cycle, then 0; `pc` reaches 0x0201, 0x0202.
- Same branch with `br_cond_met`=0 and `is_jump`=0 → no `redirect` or `flush`; `pc` 0x0014. Repeat with `is_jump`=1 → taken.
- Redirect then `stall`=1 for 3 cycles during FLUSH → `pc` holds 0x0200, `flush` held high; after the stall, the flush completes its remaining count. A `br_valid`/`halt_req` pulse during FLUSH is ignored.
- `pc`=0xFFFF unstalled → `pc`=0x0000. `halt_req` at `pc`=0x0042 → `halted`=1 and `pc`=0x0042 forever, despite `taken`.
- `rst` pulsed mid-FLUSH and in HALT → immediate `pc`=`RESET_PC`, `halted`=0, `flush`=0; normal fetch resumes.
